// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus memory slave.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dbus_pkg;

  // Width of the wait-state down-counter; WAIT_STATES must fit in it.
  localparam int WS_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Serviced request kind after priority resolution.
  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_ST = 2'd1,
    REQ_FL = 2'd2
  } req_t;

endpackage

// File: rtl/dbus_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: write commits on the clock edge; read data appears after the edge with re=1.
// Backpressure: none; the read register holds its value while re=0. Contents are never reset.
module dbus_dmem_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes: only the enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read; holds the last word read when not enabled.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dbus_dmem.sv
// Data-bus memory slave: captures one LSU load/store/flush request, waits, then acks once.
// Latency: ack is high in the (1+WAIT_STATES)th cycle after the capture edge, for one cycle.
// Backpressure: requests are held high by the LSU until ack; dropping one during WAIT aborts it.
module dbus_dmem
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dbus_addr,
  input  logic        lsu2dbus_ld_req,
  input  logic        lsu2dbus_st_req,
  input  logic [3:0]  lsu2dbus_byte_enable,
  input  logic [31:0] lsu2dbus_W_data,
  input  logic        dcache_flush_req,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,
  output logic        dbus_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WS_CNT_W-1:0] WS_LOAD = WS_CNT_W'(WAIT_STATES);

  state_t              state;
  logic [WS_CNT_W-1:0] cnt;
  req_t                type_q;
  logic                err_q;
  logic [AW-1:0]       addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                rd_sel;

  logic          any_req, cap_oor, cap_err, held, commit;
  req_t          cap_type, cur_type;
  logic          cur_err;
  logic [AW-1:0] cur_addr;
  logic [3:0]    cur_be, ram_we;
  logic [31:0]   cur_wdata, ram_rdata;
  logic          ram_re;

  // Byte offset within the word plays no part in a word access.
  logic addr_offset_unused;
  assign addr_offset_unused = ^dbus_addr[1:0];

  // Capture decode, hold check, and the RAM access issued on the edge entering RESP.
  // In IDLE the live inputs feed the RAM so a zero-wait access can commit on the capture edge.
  always_comb begin
    any_req  = lsu2dbus_ld_req | lsu2dbus_st_req | dcache_flush_req;
    cap_type = lsu2dbus_st_req ? REQ_ST : (lsu2dbus_ld_req ? REQ_LD : REQ_FL);
    cap_oor  = {2'b00, dbus_addr[31:2]} >= DEPTH_WORDS;
    cap_err  = (lsu2dbus_ld_req & lsu2dbus_st_req) |
               ((lsu2dbus_ld_req | lsu2dbus_st_req) & cap_oor);

    case (type_q)
      REQ_ST:  held = lsu2dbus_st_req;
      REQ_LD:  held = lsu2dbus_ld_req;
      default: held = dcache_flush_req;
    endcase

    if (state == S_IDLE) begin
      cur_type  = cap_type;
      cur_err   = cap_err;
      cur_addr  = dbus_addr[AW+1:2];
      cur_be    = lsu2dbus_byte_enable;
      cur_wdata = lsu2dbus_W_data;
    end else begin
      cur_type  = type_q;
      cur_err   = err_q;
      cur_addr  = addr_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
    end

    // No commit while reset is asserted: the RAM itself is not reset.
    commit = rst_n & (((state == S_IDLE) & any_req & (WAIT_STATES == 0)) |
                      ((state == S_WAIT) & held & (cnt == WS_CNT_W'(1))));
    ram_we = (commit & (cur_type == REQ_ST) & ~cur_err) ? cur_be : 4'b0000;
    ram_re = commit & (cur_type == REQ_LD) & ~cur_err;
  end

  dbus_dmem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // rd_sel and the RAM read register are both flops that only change on the edge into RESP,
  // so rdata is stable through RESP and holds afterwards; stores/flushes/errors select zero.
  assign dbus_rdata = rd_sel ? ram_rdata : 32'h0;

  // Transaction FSM: capture in IDLE, count wait states, one-cycle ack in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dbus_ack <= 1'b0;
      dbus_err <= 1'b0;
      rd_sel  <= 1'b0;
      type_q  <= REQ_LD;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dbus_ack <= 1'b0;
          dbus_err <= 1'b0;
          if (any_req) begin
            type_q  <= cap_type;
            err_q   <= cap_err;
            addr_q  <= dbus_addr[AW+1:2];
            be_q    <= lsu2dbus_byte_enable;
            wdata_q <= lsu2dbus_W_data;
            if (WAIT_STATES == 0) begin
              state    <= S_RESP;
              dbus_ack <= 1'b1;
              dbus_err <= cap_err;
              rd_sel   <= ram_re;
            end else begin
              state <= S_WAIT;
              cnt   <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!held) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == WS_CNT_W'(1)) begin
            state    <= S_RESP;
            cnt      <= '0;
            dbus_ack <= 1'b1;
            dbus_err <= err_q;
            rd_sel   <= ram_re;
          end else begin
            cnt <= cnt - WS_CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          dbus_ack <= 1'b0;
          dbus_err <= 1'b0;
        end
      endcase
    end
  end

endmodule
